// File: rtl/riscv_core_me_memory_t_if.sv
// AHB-Lite data-phase signals of the load/store port.
interface riscv_core_me_memory_t_if;
  logic        ldst_HREADY;
  logic        ldst_HRESP;
  logic [31:0] ldst_HRDATA;
  logic [31:0] ldst_HWDATA;

  modport master (
    input  ldst_HREADY,
    input  ldst_HRESP,
    input  ldst_HRDATA,
    output ldst_HWDATA
  );

  modport slave (
    output ldst_HREADY,
    output ldst_HRESP,
    output ldst_HRDATA,
    input  ldst_HWDATA
  );
endinterface

// File: rtl/riscv_core_me_memory_t.sv
// RV32 memory stage: tracks the AHB-Lite data phase of loads/stores, aligns
// and extends load data, and reports bus errors as a one-cycle exception.
module riscv_core_me_memory_t (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             ACT,
  input  logic                             ex_write,
  input  logic [1:0]                       ex_size,
  input  logic                             ex_unsigned,
  input  logic [1:0]                       ex_addr_lo,
  input  logic [31:0]                      ex_wdata,
  input  logic [4:0]                       ex_rd,
  riscv_core_me_memory_t_if.master         ldst,
  output logic                             me_stall,
  output logic                             me_wb_valid,
  output logic [4:0]                       me_wb_rd,
  output logic [31:0]                      me_wb_data,
  output logic                             me_exc
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR} state_t;

  state_t      state_q, state_d;
  logic        capture, complete, err_done;

  logic        wr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;

  logic [31:0] shifted;
  logic [31:0] load_data;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // A completing DATA cycle may accept the next address phase on the same edge.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    complete = 1'b0;
    err_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ACT && ldst.ldst_HREADY) begin
          capture = 1'b1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (ldst.ldst_HRESP) begin
          if (!ldst.ldst_HREADY) begin
            state_d = S_ERR;
          end else begin
            err_done = 1'b1;
            state_d  = S_IDLE;
          end
        end else if (ldst.ldst_HREADY) begin
          complete = 1'b1;
          if (ACT) begin
            capture = 1'b1;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ERR: begin
        if (ldst.ldst_HREADY) begin
          err_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else if (capture) begin
      wr_q    <= ex_write;
      size_q  <= ex_size;
      uns_q   <= ex_unsigned;
      addr_q  <= ex_addr_lo;
      wdata_q <= ex_wdata;
      rd_q    <= ex_rd;
    end
  end

  assign shifted = ldst.ldst_HRDATA >> {addr_q, 3'b000};

  always_comb begin
    load_data = ldst.ldst_HRDATA;
    unique case (size_q)
      2'd0:    load_data = uns_q ? {24'h0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = uns_q ? {16'h0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = ldst.ldst_HRDATA;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      me_wb_valid <= 1'b0;
      me_wb_rd    <= '0;
      me_wb_data  <= '0;
      me_exc      <= 1'b0;
    end else begin
      me_wb_valid <= complete && !wr_q;
      me_exc      <= err_done;
      if (complete && !wr_q) begin
        me_wb_rd   <= rd_q;
        me_wb_data <= load_data;
      end
    end
  end

  assign me_stall = ((state_q == S_DATA) && !ldst.ldst_HREADY) || (state_q == S_ERR);

  always_comb begin
    ldst.ldst_HWDATA = '0;
    if (state_q != S_IDLE && wr_q) ldst.ldst_HWDATA = wdata_q;
  end

endmodule

// File: tb/tb_riscv_core_me_memory_t.sv
// Directed and randomised checks of the memory stage against hand-computed
// values and an independent byte-select alignment model.
module tb_riscv_core_me_memory_t;

  logic        CLK;
  logic        RST;
  logic        ACT;
  logic        ex_write;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [1:0]  ex_addr_lo;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        me_stall;
  logic        me_wb_valid;
  logic [4:0]  me_wb_rd;
  logic [31:0] me_wb_data;
  logic        me_exc;

  int n_checks;
  int n_pass;

  riscv_core_me_memory_t_if bus ();

  riscv_core_me_memory_t dut (
    .CLK         (CLK),
    .RST         (RST),
    .ACT         (ACT),
    .ex_write    (ex_write),
    .ex_size     (ex_size),
    .ex_unsigned (ex_unsigned),
    .ex_addr_lo  (ex_addr_lo),
    .ex_wdata    (ex_wdata),
    .ex_rd       (ex_rd),
    .ldst        (bus.master),
    .me_stall    (me_stall),
    .me_wb_valid (me_wb_valid),
    .me_wb_rd    (me_wb_rd),
    .me_wb_data  (me_wb_data),
    .me_exc      (me_exc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic act, input logic wr, input logic [1:0] sz,
                       input logic un, input logic [1:0] al, input logic [31:0] wd,
                       input logic [4:0] rd, input logic hr, input logic hs,
                       input logic [31:0] rdat);
    @(negedge CLK);
    ACT             = act;
    ex_write        = wr;
    ex_size         = sz;
    ex_unsigned     = un;
    ex_addr_lo      = al;
    ex_wdata        = wd;
    ex_rd           = rd;
    bus.ldst_HREADY = hr;
    bus.ldst_HRESP  = hs;
    bus.ldst_HRDATA = rdat;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] ref_align(input logic [31:0] d, input logic [1:0] sz,
                                            input logic un, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    case (a)
      2'd0:    h = d[15:0];
      2'd1:    h = d[23:8];
      2'd2:    h = d[31:16];
      default: h = {8'h00, d[31:24]};
    endcase
    case (sz)
      2'd0:    return un ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    return un ? {16'h0, h} : {{16{h[15]}}, h};
      default: return d;
    endcase
  endfunction

  task automatic test_reset();
    RST = 1'b0;
    drive(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b0, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF);
    n_checks++; if (me_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", me_stall); else n_pass++;
    n_checks++; if (me_wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %b expected 0", me_wb_valid); else n_pass++;
    n_checks++; if (me_wb_rd !== 5'd0) $display("FAIL reset_wb_rd: got %h expected 0", me_wb_rd); else n_pass++;
    n_checks++; if (me_wb_data !== 32'h0) $display("FAIL reset_wb_data: got %h expected 0", me_wb_data); else n_pass++;
    n_checks++; if (me_exc !== 1'b0) $display("FAIL reset_exc: got %b expected 0", me_exc); else n_pass++;
    n_checks++; if (bus.ldst_HWDATA !== 32'h0) $display("FAIL reset_hwdata: got %h expected 0", bus.ldst_HWDATA); else n_pass++;
    idle();
    RST = 1'b1;
    idle();
    n_checks++; if (me_wb_valid !== 1'b0) $display("FAIL reset_release_wb: got %b expected 0", me_wb_valid); else n_pass++;
  endtask

  task automatic test_load_align();
    logic [1:0]  t_al [6];
    logic [1:0]  t_sz [6];
    logic        t_un [6];
    logic [31:0] t_rd [6];
    logic [31:0] t_ex [6];
    t_al = '{2'd3, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0};
    t_sz = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1};
    t_un = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    t_rd = '{32'h80FF_FF00, 32'h80FF_FF00, 32'hAB00_0000, 32'h0080_0000, 32'h8765_4321, 32'h0000_F00D};
    t_ex = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_00AB, 32'hFFFF_8000, 32'h8765_4321, 32'h0000_F00D};
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, t_sz[k], t_un[k], t_al[k], 32'h0, 5'(10 + k), 1'b1, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 5'd0, 1'b1, 1'b0, t_rd[k]);
      n_checks++; if (me_stall !== 1'b0) $display("FAIL align%0d_stall: got %b expected 0", k, me_stall); else n_pass++;
      n_checks++; if (me_wb_valid !== 1'b0) $display("FAIL align%0d_early_wb: got %b expected 0", k, me_wb_valid); else n_pass++;
      idle();
      n_checks++; if (me_wb_valid !== 1'b1) $display("FAIL align%0d_wb_valid: got %b expected 1", k, me_wb_valid); else n_pass++;
      n_checks++; if (me_wb_rd !== 5'(10 + k)) $display("FAIL align%0d_wb_rd: got %0d expected %0d", k, me_wb_rd, 10 + k); else n_pass++;
      n_checks++; if (me_wb_data !== t_ex[k]) $display("FAIL align%0d_wb_data: got %h expected %h", k, me_wb_data, t_ex[k]); else n_pass++;
      n_checks++; if (me_exc !== 1'b0) $display("FAIL align%0d_exc: got %b expected 0", k, me_exc); else n_pass++;
      idle();
      n_checks++; if (me_wb_valid !== 1'b0) $display("FAIL align%0d_pulse_width: got %b expected 0", k, me_wb_valid); else n_pass++;
    end
  endtask

  task automatic test_wait_states();
    int n_stall;
    n_stall = 0;
    drive(1'b1, 1'b0, 2'd1, 1'b0, 2'd2, 32'h0, 5'd9, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 5'd0, 1'b0, 1'b0, 32'hDEAD_0000);
    if (me_stall === 1'b1) n_stall++;
    drive(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0000_BEEF);
    if (me_stall === 1'b1) n_stall++;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h1234_5678);
    if (me_stall === 1'b1) n_stall++;
    n_checks++; if (me_wb_valid !== 1'b0) $display("FAIL wait_early_wb: got %b expected 0", me_wb_valid); else n_pass++;
    n_checks++; if (n_stall != 2) $display("FAIL wait_stall_cycles: got %0d expected 2", n_stall); else n_pass++;
    idle();
    n_checks++; if (me_wb_valid !== 1'b1) $display("FAIL wait_wb_valid: got %b expected 1", me_wb_valid); else n_pass++;
    n_checks++; if (me_wb_rd !== 5'd9) $display("FAIL wait_wb_rd: got %0d expected 9", me_wb_rd); else n_pass++;
    n_checks++; if (me_wb_data !== 32'h0000_1234) $display("FAIL wait_wb_data: got %h expected 00001234", me_wb_data); else n_pass++;
    idle();
    n_checks++; if (me_wb_valid !== 1'b0) $display("FAIL wait_pulse_width: got %b expected 0", me_wb_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 32'hDEAD_BEEF, 5'd1, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 32'h0, 5'd7, 1'b1, 1'b0, 32'h5555_5555);
    n_checks++; if (bus.ldst_HWDATA !== 32'hDEAD_BEEF) $display("FAIL b2b_hwdata: got %h expected deadbeef", bus.ldst_HWDATA); else n_pass++;
    n_checks++; if (me_stall !== 1'b0) $display("FAIL b2b_stall: got %b expected 0", me_stall); else n_pass++;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0000_0042);
    n_checks++; if (me_wb_valid !== 1'b0) $display("FAIL b2b_store_wb: got %b expected 0", me_wb_valid); else n_pass++;
    n_checks++; if (bus.ldst_HWDATA !== 32'h0) $display("FAIL b2b_load_hwdata: got %h expected 0", bus.ldst_HWDATA); else n_pass++;
    idle();
    n_checks++; if (me_wb_valid !== 1'b1) $display("FAIL b2b_wb_valid: got %b expected 1", me_wb_valid); else n_pass++;
    n_checks++; if (me_wb_rd !== 5'd7) $display("FAIL b2b_wb_rd: got %0d expected 7", me_wb_rd); else n_pass++;
    n_checks++; if (me_wb_data !== 32'h0000_0042) $display("FAIL b2b_wb_data: got %h expected 00000042", me_wb_data); else n_pass++;
    idle();
    n_checks++; if (me_wb_valid !== 1'b0) $display("FAIL b2b_pulse_width: got %b expected 0", me_wb_valid); else n_pass++;
  endtask

  task automatic test_bus_error();
    int n_stall;
    n_stall = 0;
    drive(1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 32'h0, 5'd5, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h1111_1111);
    if (me_stall === 1'b1) n_stall++;
    drive(1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 32'h0, 5'd4, 1'b1, 1'b1, 32'h2222_2222);
    if (me_stall === 1'b1) n_stall++;
    n_checks++; if (me_exc !== 1'b0) $display("FAIL err_early_exc: got %b expected 0", me_exc); else n_pass++;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h3333_3333);
    if (me_stall === 1'b1) n_stall++;
    n_checks++; if (n_stall != 2) $display("FAIL err_stall_cycles: got %0d expected 2", n_stall); else n_pass++;
    n_checks++; if (me_exc !== 1'b1) $display("FAIL err_exc: got %b expected 1", me_exc); else n_pass++;
    n_checks++; if (me_wb_valid !== 1'b0) $display("FAIL err_wb_with_exc: got %b expected 0", me_wb_valid); else n_pass++;
    idle();
    n_checks++; if (me_exc !== 1'b0) $display("FAIL err_exc_width: got %b expected 0", me_exc); else n_pass++;
    n_checks++; if (me_wb_valid !== 1'b0) $display("FAIL err_act_ignored: got %b expected 0", me_wb_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 32'h0, 5'd6, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (me_stall !== 1'b1) $display("FAIL rmid_pre_stall: got %b expected 1", me_stall); else n_pass++;
    RST = 1'b0;
    #1;
    n_checks++; if (me_stall !== 1'b0) $display("FAIL rmid_stall: got %b expected 0", me_stall); else n_pass++;
    n_checks++; if (me_wb_valid !== 1'b0 || me_exc !== 1'b0) $display("FAIL rmid_pulses: got wb=%b exc=%b expected 0 0", me_wb_valid, me_exc); else n_pass++;
    idle();
    RST = 1'b1;
    idle();
    n_checks++; if (me_wb_valid !== 1'b0 || me_exc !== 1'b0) $display("FAIL rmid_release1: got wb=%b exc=%b expected 0 0", me_wb_valid, me_exc); else n_pass++;
    idle();
    n_checks++; if (me_wb_valid !== 1'b0 || me_exc !== 1'b0) $display("FAIL rmid_release2: got wb=%b exc=%b expected 0 0", me_wb_valid, me_exc); else n_pass++;
    drive(1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 32'h0, 5'd12, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0000_1357);
    idle();
    n_checks++; if (me_wb_valid !== 1'b1) $display("FAIL rmid_next_wb: got %b expected 1", me_wb_valid); else n_pass++;
    n_checks++; if (me_wb_data !== 32'h0000_1357) $display("FAIL rmid_next_data: got %h expected 00001357", me_wb_data); else n_pass++;
    idle();
  endtask

  task automatic test_random();
    logic        pend, pend_wr, hr, act, wr, un;
    logic [1:0]  sz, al;
    logic [4:0]  pend_rd, rd, exp_rd;
    logic [31:0] pend_wd, pend_rdata, wd, exp_d, rdat;
    logic        exp_v, done;
    logic [1:0]  pend_sz, pend_al;
    logic        pend_un;
    int unsigned waits;
    int n_loads, n_wb, n_fail_local;
    pend = 1'b0; pend_wr = 1'b0; pend_rd = '0; pend_wd = '0; pend_rdata = '0;
    pend_sz = '0; pend_al = '0; pend_un = 1'b0;
    exp_v = 1'b0; exp_rd = '0; exp_d = '0; waits = 0;
    n_loads = 0; n_wb = 0; n_fail_local = 0;
    for (int i = 0; i < 300; i++) begin
      hr = !(pend && waits > 0);
      if (pend && waits > 0) waits--;
      act = (i < 290) && ($urandom_range(0, 3) != 0);
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      un = 1'($urandom_range(0, 1));
      al = 2'($urandom_range(0, 3));
      wd = $urandom;
      rd = 5'($urandom_range(0, 31));
      rdat = pend ? pend_rdata : $urandom;
      drive(act, wr, sz, un, al, wd, rd, hr, 1'b0, rdat);
      n_checks++;
      if (me_wb_valid !== exp_v) begin
        $display("FAIL rand_wb_valid cycle %0d: got %b expected %b", i, me_wb_valid, exp_v);
        n_fail_local++;
      end else n_pass++;
      if (exp_v) begin
        n_checks++; if (me_wb_rd !== exp_rd) $display("FAIL rand_wb_rd cycle %0d: got %0d expected %0d", i, me_wb_rd, exp_rd); else n_pass++;
        n_checks++; if (me_wb_data !== exp_d) $display("FAIL rand_wb_data cycle %0d: got %h expected %h", i, me_wb_data, exp_d); else n_pass++;
      end
      n_checks++; if (me_stall !== (pend && !hr)) $display("FAIL rand_stall cycle %0d: got %b expected %b", i, me_stall, pend && !hr); else n_pass++;
      n_checks++; if (bus.ldst_HWDATA !== ((pend && pend_wr) ? pend_wd : 32'h0)) $display("FAIL rand_hwdata cycle %0d: got %h expected %h", i, bus.ldst_HWDATA, (pend && pend_wr) ? pend_wd : 32'h0); else n_pass++;
      if (me_wb_valid === 1'b1) n_wb++;
      done  = pend && hr;
      exp_v = done && !pend_wr;
      if (exp_v) begin
        exp_rd = pend_rd;
        exp_d  = ref_align(pend_rdata, pend_sz, pend_un, pend_al);
      end
      if (act && hr) begin
        pend       = 1'b1;
        pend_wr    = wr;
        pend_sz    = sz;
        pend_un    = un;
        pend_al    = al;
        pend_wd    = wd;
        pend_rd    = rd;
        pend_rdata = $urandom;
        waits      = $urandom_range(0, 2);
        if (!wr) n_loads++;
      end else if (done) begin
        pend = 1'b0;
      end
    end
    n_checks++; if (n_wb != n_loads) $display("FAIL rand_wb_count: got %0d expected %0d", n_wb, n_loads); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    RST = 1'b0;
    ACT = 1'b0; ex_write = 1'b0; ex_size = '0; ex_unsigned = 1'b0;
    ex_addr_lo = '0; ex_wdata = '0; ex_rd = '0;
    bus.ldst_HREADY = 1'b1; bus.ldst_HRESP = 1'b0; bus.ldst_HRDATA = '0;
    test_reset();
    test_load_align();
    test_wait_states();
    test_back_to_back();
    test_bus_error();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
